// File: rtl/spi_control_fsm.sv
// SPI transaction controller: sequences address capture, then a read (load + MISO drive)
// or write (receive + memory store) of one data byte per chip-select frame.
module spi_control_fsm #(
  parameter int unsigned width      = 8,
  parameter int unsigned countWidth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic chipSelect,
  input  logic peripheralClkEdge,
  input  logic rwBit,
  output logic addrLatchEnable,
  output logic parallelLoad,
  output logic misoBufEnable,
  output logic dmWriteEnable,
  output logic busy
);

  localparam logic [countWidth-1:0] LastBit = countWidth'(width - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_LOAD,
    READ_SEND,
    WRITE_RECV,
    WRITE_STORE,
    DONE
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [countWidth-1:0] bit_count;
  logic [countWidth-1:0] next_count;
  logic                  last_strobe;
  logic                  counting;
  logic                  next_ale;
  logic                  next_load;
  logic                  next_miso;
  logic                  next_write;
  logic                  next_busy;

  assign last_strobe = peripheralClkEdge && (bit_count == LastBit);
  assign counting    = (state == GET_ADDR) || (state == READ_SEND) || (state == WRITE_RECV);

  // State, bit counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bit_count       <= '0;
      addrLatchEnable <= 1'b0;
      parallelLoad    <= 1'b0;
      misoBufEnable   <= 1'b0;
      dmWriteEnable   <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= next_state;
      bit_count       <= next_count;
      addrLatchEnable <= next_ale;
      parallelLoad    <= next_load;
      misoBufEnable   <= next_miso;
      dmWriteEnable   <= next_write;
      busy            <= next_busy;
    end
  end

  // Next state; CS high outside IDLE aborts ahead of any final strobe
  always_comb begin
    next_state = state;
    if (state != IDLE && chipSelect) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:        if (!chipSelect) next_state = GET_ADDR;
        GET_ADDR:    if (last_strobe) next_state = GOT_ADDR;
        GOT_ADDR:    next_state = rwBit ? READ_LOAD : WRITE_RECV;
        READ_LOAD:   next_state = READ_SEND;
        READ_SEND:   if (last_strobe) next_state = DONE;
        WRITE_RECV:  if (last_strobe) next_state = WRITE_STORE;
        WRITE_STORE: next_state = DONE;
        DONE:        next_state = DONE;
        default:     next_state = IDLE;
      endcase
    end

    next_count = bit_count;
    if (next_state != state) begin
      next_count = '0;
    end else if (peripheralClkEdge && counting) begin
      next_count = bit_count + 1'b1;
    end
  end

  // Outputs decoded from the state being entered, so they line up with that state
  always_comb begin
    next_ale   = 1'b0;
    next_load  = 1'b0;
    next_miso  = 1'b0;
    next_write = 1'b0;
    next_busy  = (next_state != IDLE);
    unique case (next_state)
      GOT_ADDR:    next_ale   = 1'b1;
      READ_LOAD:   next_load  = 1'b1;
      READ_SEND:   next_miso  = 1'b1;
      WRITE_STORE: next_write = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_spi_control_fsm.sv
// Bench for spi_control_fsm: vector table for reset/idle/abort basics, then hand-built
// write, read, abort, race and mid-read reset transactions, all checked via a scoreboard.
module tb_spi_control_fsm;

  logic clk = 1'b0;
  logic reset, chipSelect, peripheralClkEdge, rwBit;
  logic addrLatchEnable, parallelLoad, misoBufEnable, dmWriteEnable, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] e;
    string      name;
  } sb_t;

  typedef struct {
    logic       r;
    logic       cs;
    logic       stb;
    logic       rw;
    logic [4:0] e;
    string      name;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[10];

  // Expected output encodings {ale, load, miso, write, busy}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_BUSY = 5'b00001;
  localparam logic [4:0] O_ALE  = 5'b10001;
  localparam logic [4:0] O_LOAD = 5'b01001;
  localparam logic [4:0] O_MISO = 5'b00101;
  localparam logic [4:0] O_WR   = 5'b00011;

  always #5 clk = ~clk;

  spi_control_fsm #(.width(8), .countWidth(4)) dut (
    .clk(clk),
    .reset(reset),
    .chipSelect(chipSelect),
    .peripheralClkEdge(peripheralClkEdge),
    .rwBit(rwBit),
    .addrLatchEnable(addrLatchEnable),
    .parallelLoad(parallelLoad),
    .misoBufEnable(misoBufEnable),
    .dmWriteEnable(dmWriteEnable),
    .busy(busy)
  );

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {ale,load,miso,wr,busy}=%b want %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic cs, input logic stb, input logic rw,
                      input logic [4:0] e, input string name);
    sb_t x;
    @(negedge clk);
    reset = r;
    chipSelect = cs;
    peripheralClkEdge = stb;
    rwBit = rw;
    sb.push_back('{e: e, name: name});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(x.name, {addrLatchEnable, parallelLoad, misoBufEnable, dmWriteEnable, busy}, x.e);
  endtask

  task automatic check_count_zero(input string name);
    checks++;
    if (dut.bit_count !== 4'd0) begin
      errors++;
      $display("FAIL %s: bit_count got %0d want 0", name, dut.bit_count);
    end
  endtask

  // Address byte from GET_ADDR; leaves FSM in GOT_ADDR (ALE visible)
  task automatic addr_byte(input logic rw);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, rw, (i == 7) ? O_ALE : O_BUSY, "addr_strobe");
      if (i != 7) step(1'b0, 1'b0, 1'b0, rw, O_BUSY, "addr_gap");
    end
  endtask

  initial begin
    reset = 1'b1;
    chipSelect = 1'b0;
    peripheralClkEdge = 1'b0;
    rwBit = 1'b0;

    vecs[0] = '{r: 1'b1, cs: 1'b0, stb: 1'b0, rw: 1'b0, e: O_IDLE, name: "reset_cs_low_0"};
    vecs[1] = '{r: 1'b1, cs: 1'b0, stb: 1'b1, rw: 1'b0, e: O_IDLE, name: "reset_cs_low_1"};
    vecs[2] = '{r: 1'b0, cs: 1'b1, stb: 1'b1, rw: 1'b0, e: O_IDLE, name: "idle_strobe_ign"};
    vecs[3] = '{r: 1'b0, cs: 1'b1, stb: 1'b0, rw: 1'b0, e: O_IDLE, name: "idle_cs_high"};
    vecs[4] = '{r: 1'b0, cs: 1'b0, stb: 1'b0, rw: 1'b0, e: O_BUSY, name: "enter_get_addr"};
    vecs[5] = '{r: 1'b0, cs: 1'b0, stb: 1'b1, rw: 1'b0, e: O_BUSY, name: "first_strobe"};
    vecs[6] = '{r: 1'b0, cs: 1'b1, stb: 1'b0, rw: 1'b0, e: O_IDLE, name: "early_abort"};
    vecs[7] = '{r: 1'b0, cs: 1'b0, stb: 1'b0, rw: 1'b0, e: O_BUSY, name: "reenter"};
    vecs[8] = '{r: 1'b1, cs: 1'b0, stb: 1'b0, rw: 1'b0, e: O_IDLE, name: "reset_overrides"};
    vecs[9] = '{r: 1'b0, cs: 1'b1, stb: 1'b0, rw: 1'b0, e: O_IDLE, name: "idle_after_rst"};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].cs, vecs[i].stb, vecs[i].rw, vecs[i].e, vecs[i].name);
      if (i == 1) check_count_zero("reset_count");
    end

    // Write transaction
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "wr_enter");
    addr_byte(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "wr_recv");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, (i == 7) ? O_WR : O_BUSY, "wr_data_strobe");
      step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "wr_data_gap");
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY, "wr_extra_strobe");
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "wr_done_hold");
    step(1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, "wr_cs_release");

    // Read transaction
    step(1'b0, 1'b0, 1'b0, 1'b1, O_BUSY, "rd_enter");
    addr_byte(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, O_LOAD, "rd_load");
    step(1'b0, 1'b0, 1'b0, 1'b1, O_MISO, "rd_send_start");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, (i == 7) ? O_BUSY : O_MISO, "rd_data_strobe");
      step(1'b0, 1'b0, 1'b0, 1'b1, (i == 7) ? O_BUSY : O_MISO, "rd_data_gap");
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, "rd_cs_release");

    // Abort after 5 address strobes, then a full new address byte
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "ab_enter");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY, "ab_strobe");
      step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "ab_gap");
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, "ab_abort");
    check_count_zero("ab_count");
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "ab_reenter");
    addr_byte(1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, "ab_cs_release");

    // CS rises with the final write strobe: no store
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "race_enter");
    addr_byte(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "race_recv");
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, O_BUSY, "race_strobe");
      step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "race_gap");
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, O_IDLE, "race_final");
    step(1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, "race_no_write_0");
    step(1'b0, 1'b1, 1'b0, 1'b0, O_IDLE, "race_no_write_1");

    // Reset during READ_SEND after 3 strobes
    step(1'b0, 1'b0, 1'b0, 1'b1, O_BUSY, "mr_enter");
    addr_byte(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, O_LOAD, "mr_load");
    step(1'b0, 1'b0, 1'b0, 1'b1, O_MISO, "mr_send");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, O_MISO, "mr_strobe");
      step(1'b0, 1'b0, 1'b0, 1'b1, O_MISO, "mr_gap");
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, O_IDLE, "mr_reset");
    check_count_zero("mr_count");
    step(1'b0, 1'b0, 1'b0, 1'b0, O_BUSY, "mr_restart");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
